// File: rtl/host_cpu_oci_dct_packer_if.sv
// Trace-atom input, frame output and end-of-test signals of the OCI DCT packer.
// The master side feeds atoms and consumes frames; the packer is the slave.
interface host_cpu_oci_dct_packer_if;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush;
    logic        end_req;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready;
    logic        test_ending;
    logic        test_has_ended;

    modport master (
        output atom_valid, atom, flush, end_req, dct_ready,
        input  atom_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
    );

    modport slave (
        input  atom_valid, atom, flush, end_req, dct_ready,
        output atom_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
    );
endinterface

// File: rtl/host_cpu_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit frames for the OCI trace sink and
// sequences the drain / end-of-test handshake once tracing is finished.
module host_cpu_oci_dct_packer #(
    parameter int ATOMS_PER_FRAME   = 15,
    parameter int IDLE_FLUSH_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    host_cpu_oci_dct_packer_if.slave bus
);

    localparam int IDLE_W_RAW = $clog2(IDLE_FLUSH_CYCLES + 1);
    localparam int IDLE_W     = (IDLE_W_RAW < 1) ? 1 : IDLE_W_RAW;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        ENDING,
        ENDED
    } state_t;

    state_t            state;
    logic [29:0]       acc;
    logic [3:0]        acc_cnt;
    logic              sealed;
    logic [IDLE_W-1:0] idle_cnt;
    logic [29:0]       out_buf;
    logic [3:0]        out_cnt;
    logic              out_valid;
    logic              ending;
    logic              ended;

    logic              accept;
    logic [29:0]       atom_shifted;
    logic [29:0]       nxt_acc;
    logic [3:0]        nxt_cnt;
    logic              idle_hit;
    logic              seal_now;
    logic              slot_free;
    logic              move;
    logic              drained;

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign bus.atom_ready     = !reset && (state == RUN) && !sealed;
    assign bus.dct_buffer     = out_buf;
    assign bus.dct_count      = out_cnt;
    assign bus.dct_valid      = out_valid;
    assign bus.test_ending    = ending;
    assign bus.test_has_ended = ended;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        accept       = 1'b0;
        atom_shifted = '0;
        nxt_acc      = acc;
        nxt_cnt      = acc_cnt;
        idle_hit     = 1'b0;
        seal_now     = 1'b0;
        slot_free    = 1'b0;
        move         = 1'b0;
        drained      = 1'b0;

        accept       = bus.atom_valid && bus.atom_ready;
        atom_shifted = {28'd0, bus.atom} << {acc_cnt, 1'b0};
        if (accept) begin
            nxt_acc = acc | atom_shifted;
            nxt_cnt = acc_cnt + 4'd1;
        end

        idle_hit = (IDLE_FLUSH_CYCLES != 0) && (idle_cnt == IDLE_W'(IDLE_FLUSH_CYCLES));

        // Seal decision looks at post-accept contents; an empty accumulator never seals.
        seal_now = (nxt_cnt != 4'd0) &&
                   ((nxt_cnt == 4'(ATOMS_PER_FRAME)) || bus.flush || idle_hit || (state == DRAIN));

        slot_free = !out_valid || bus.dct_ready;
        move      = (sealed || seal_now) && slot_free;
        drained   = (acc_cnt == 4'd0) && !sealed && slot_free;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: acc and the output register are reset too, not just their valid bits,
            // because zero-fill of unused frame bits relies on acc starting from 0.
            state     <= RUN;
            acc       <= '0;
            acc_cnt   <= '0;
            sealed    <= 1'b0;
            idle_cnt  <= '0;
            out_buf   <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            ending    <= 1'b0;
            ended     <= 1'b0;
        end else begin
            if (move) begin
                out_buf   <= nxt_acc;
                out_cnt   <= nxt_cnt;
                out_valid <= 1'b1;
                acc       <= '0;
                acc_cnt   <= '0;
                sealed    <= 1'b0;
            end else begin
                acc     <= nxt_acc;
                acc_cnt <= nxt_cnt;
                if (seal_now) begin
                    sealed <= 1'b1;
                end
                if (out_valid && bus.dct_ready) begin
                    out_valid <= 1'b0;
                end
            end

            if (accept || seal_now || sealed || (acc_cnt == 4'd0)) begin
                idle_cnt <= '0;
            end else if (!idle_hit) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            unique case (state)
                RUN: begin
                    if (bus.end_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leaves on the same edge the last frame transfers.
                    if (drained) begin
                        state  <= ENDING;
                        ending <= 1'b1;
                    end
                end
                ENDING: begin
                    ending <= 1'b0;
                    ended  <= 1'b1;
                    state  <= ENDED;
                end
                ENDED: begin
                    state <= ENDED;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_host_cpu_oci_dct_packer.sv
// Directed bench for the OCI DCT packer: a vector table for plain packing and
// flush, hand-written sequences for backpressure, idle flush, drain and reset.
module tb_host_cpu_oci_dct_packer;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    host_cpu_oci_dct_packer_if bus ();

    host_cpu_oci_dct_packer #(
        .ATOMS_PER_FRAME  (15),
        .IDLE_FLUSH_CYCLES(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  a;
        logic        fl;
        logic        er;
        logic        rdy;
        logic        e_ar;
        logic        e_dv;
        logic        chk;
        logic [29:0] e_buf;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic fl,
                         input logic er, input logic rdy);
        bus.atom_valid = v;
        bus.atom       = a;
        bus.flush      = fl;
        bus.end_req    = er;
        bus.dct_ready  = rdy;
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] a, input logic fl,
                                input logic rdy, input logic e_ar, input logic e_dv,
                                input logic chk, input logic [29:0] e_buf,
                                input logic [3:0] e_cnt);
        vec_t r;
        r.v = v; r.a = a; r.fl = fl; r.er = 1'b0; r.rdy = rdy;
        r.e_ar = e_ar; r.e_dv = e_dv; r.chk = chk; r.e_buf = e_buf; r.e_cnt = e_cnt;
        return r;
    endfunction

    initial begin
        logic [29:0] held_buf;
        int          n;
        logic        seen;

        total = 0;
        bad   = 0;

        // Plain packing of 0,1,2,3,... then 3,3,1 + flush, then a no-op flush.
        for (int k = 0; k < 15; k++) begin
            vecs.push_back(mk(1'b1, 2'(k % 4), 1'b0, 1'b1, 1'b1, (k == 14), (k == 14),
                              30'h24E4E4E4, 4'hF));
        end
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h0, 4'h0));
        vecs.push_back(mk(1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h0, 4'h0));
        vecs.push_back(mk(1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h0, 4'h0));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h0, 4'h0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 30'h0000001F, 4'h3));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h0, 4'h0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 30'h0, 4'h0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'h0, 4'h0));

        // Reset state.
        reset = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("reset_atom_ready", 32'(bus.atom_ready), 32'd0);
        check("reset_dct_valid", 32'(bus.dct_valid), 32'd0);
        check("reset_dct_buffer", 32'(bus.dct_buffer), 32'd0);
        check("reset_dct_count", 32'(bus.dct_count), 32'd0);
        check("reset_test_ending", 32'(bus.test_ending), 32'd0);
        check("reset_test_has_ended", 32'(bus.test_has_ended), 32'd0);
        reset = 1'b0;
        #1;
        check("post_reset_atom_ready", 32'(bus.atom_ready), 32'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].a, vecs[i].fl, vecs[i].er, vecs[i].rdy);
            #1;
            check($sformatf("vec%0d_atom_ready", i), 32'(bus.atom_ready), 32'(vecs[i].e_ar));
            step();
            check($sformatf("vec%0d_dct_valid", i), 32'(bus.dct_valid), 32'(vecs[i].e_dv));
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_dct_buffer", i), 32'(bus.dct_buffer), 32'(vecs[i].e_buf));
                check($sformatf("vec%0d_dct_count", i), 32'(bus.dct_count), 32'(vecs[i].e_cnt));
            end
        end

        // Backpressure: frame 1 held, frame 2 sealed, atom 31 refused until release.
        for (int k = 0; k < 30; k++) begin
            drive(1'b1, (k < 15) ? 2'd1 : 2'd2, 1'b0, 1'b0, 1'b0);
            #1;
            check($sformatf("bp_atom_ready_%0d", k), 32'(bus.atom_ready), 32'd1);
            step();
            if (k >= 14) begin
                check($sformatf("bp_frame1_buffer_%0d", k), 32'(bus.dct_buffer), 32'h15555555);
            end
        end
        check("bp_frame1_valid", 32'(bus.dct_valid), 32'd1);
        check("bp_frame1_count", 32'(bus.dct_count), 32'd15);
        held_buf = bus.dct_buffer;
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_atom31_refused", 32'(bus.atom_ready), 32'd0);
            step();
            check("bp_frame1_stable", 32'(bus.dct_buffer), 32'(held_buf));
        end
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        check("bp_frame2_valid", 32'(bus.dct_valid), 32'd1);
        check("bp_frame2_buffer", 32'(bus.dct_buffer), 32'h2AAAAAAA);
        check("bp_frame2_count", 32'(bus.dct_count), 32'd15);
        check("bp_atom31_ready", 32'(bus.atom_ready), 32'd1);
        step();
        check("bp_frame2_taken", 32'(bus.dct_valid), 32'd0);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        step();
        check("bp_atom31_frame_valid", 32'(bus.dct_valid), 32'd1);
        check("bp_atom31_frame_buffer", 32'(bus.dct_buffer), 32'h3);
        check("bp_atom31_frame_count", 32'(bus.dct_count), 32'd1);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("bp_idle_valid", 32'(bus.dct_valid), 32'd0);

        // Idle flush: 5 atoms of 2'b10, frame expected 65 cycles after the last accept.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!bus.dct_valid && n < 200) begin
            step();
            n++;
        end
        check("idle_flush_latency", 32'(n), 32'd65);
        check("idle_flush_buffer", 32'(bus.dct_buffer), 32'h2AA);
        check("idle_flush_count", 32'(bus.dct_count), 32'd5);
        step();
        check("idle_flush_taken", 32'(bus.dct_valid), 32'd0);

        // Drain and end-of-test with 7 atoms pending.
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("drain_atom_ready", 32'(bus.atom_ready), 32'd0);
        check("drain_not_yet_valid", 32'(bus.dct_valid), 32'd0);
        step();
        check("drain_frame_valid", 32'(bus.dct_valid), 32'd1);
        check("drain_frame_buffer", 32'(bus.dct_buffer), 32'h1555);
        check("drain_frame_count", 32'(bus.dct_count), 32'd7);
        check("drain_no_early_ending", 32'(bus.test_ending), 32'd0);
        step();
        check("ending_pulse", 32'(bus.test_ending), 32'd1);
        check("ending_frame_gone", 32'(bus.dct_valid), 32'd0);
        check("ending_not_ended_yet", 32'(bus.test_has_ended), 32'd0);
        check("ending_atom_ready", 32'(bus.atom_ready), 32'd0);
        step();
        check("ended_pulse_over", 32'(bus.test_ending), 32'd0);
        check("ended_set", 32'(bus.test_has_ended), 32'd1);
        drive(1'b1, 2'd3, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("ended_sticky", 32'(bus.test_has_ended), 32'd1);
            check("ended_atom_ready", 32'(bus.atom_ready), 32'd0);
            check("ended_no_frame", 32'(bus.dct_valid), 32'd0);
            check("ended_no_pulse", 32'(bus.test_ending), 32'd0);
        end

        // Reset mid-frame with a held frame and 8 atoms pending.
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 23; k++) begin
            drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
            step();
        end
        check("rst_pre_valid", 32'(bus.dct_valid), 32'd1);
        check("rst_pre_atom_ready", 32'(bus.atom_ready), 32'd1);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check("rst_mid_valid", 32'(bus.dct_valid), 32'd0);
        check("rst_mid_buffer", 32'(bus.dct_buffer), 32'd0);
        check("rst_mid_count", 32'(bus.dct_count), 32'd0);
        check("rst_mid_atom_ready", 32'(bus.atom_ready), 32'd0);
        check("rst_mid_ended", 32'(bus.test_has_ended), 32'd0);
        reset = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (bus.dct_valid) seen = 1'b1;
        end
        check("rst_no_stale_frame", 32'(seen), 32'd0);
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("rst_restart_valid", 32'(bus.dct_valid), 32'd1);
        check("rst_restart_buffer", 32'(bus.dct_buffer), 32'h7);
        check("rst_restart_count", 32'(bus.dct_count), 32'd2);
        step();
        check("rst_restart_taken", 32'(bus.dct_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
